// File: rtl/auc_mladder_ctl.sv
// Montgomery-ladder bit scheduler: loads the decoded scalar once, then issues one
// ladder-step request per bit (MSB first) with the cswap flag, plus a final swap-only request.
module auc_mladder_ctl #(
  parameter int WID     = 256,
  parameter int AWID    = 5,
  parameter int NBIT    = 255,
  parameter int CWID    = 8,
  parameter int RDLAT   = 2,
  parameter int KADDR   = 11,
  parameter int IDLADDR = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ladd_en,
  output logic            ladd_done,
  output logic            ladd_busy,
  output logic [AWID-1:0] ladd_ra,
  input  logic [WID-1:0]  ladd_rd,
  output logic            step_req,
  output logic            step_swap,
  output logic            step_final,
  output logic [CWID-1:0] step_bit,
  input  logic            step_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_RDK, S_WAITK, S_LOAD, S_STEP, S_SWAIT, S_FINAL, S_FWAIT, S_DONE
  } state_t;

  localparam logic [AWID-1:0] L_KADDR   = AWID'(KADDR);
  localparam logic [AWID-1:0] L_IDLADDR = AWID'(IDLADDR);
  localparam logic [CWID-1:0] L_LASTBIT = CWID'(NBIT - 1);
  localparam logic [2:0]      L_LATMAX  = 3'(RDLAT - 1);

  state_t          r_state, w_next;
  logic [WID-1:0]  r_kreg;
  logic            r_swap_acc;
  logic [CWID-1:0] r_bitcnt;
  logic [2:0]      r_latcnt;
  logic [AWID-1:0] r_ra;
  logic            r_step_req;
  logic            r_step_swap;
  logic            r_step_final;
  logic [CWID-1:0] r_step_bit;
  logic            w_kbit;

  assign w_kbit = r_kreg[r_bitcnt];

  always_comb begin
    w_next    = r_state;
    ladd_done = 1'b0;
    ladd_busy = 1'b1;
    case (r_state)
      S_IDLE: begin
        ladd_busy = 1'b0;
        if (ladd_en) w_next = S_RDK;
      end
      S_RDK:   w_next = S_WAITK;
      S_WAITK: if (r_latcnt == L_LATMAX) w_next = S_LOAD;
      S_LOAD:  w_next = S_STEP;
      S_STEP:  w_next = S_SWAIT;
      S_SWAIT: if (step_done) w_next = (r_bitcnt == '0) ? S_FINAL : S_STEP;
      S_FINAL: w_next = S_FWAIT;
      S_FWAIT: if (step_done) w_next = S_DONE;
      S_DONE: begin
        ladd_done = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are registered together with step_req so they are valid
  // in the same cycle the datapath sees the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_kreg       <= '0;
      r_swap_acc   <= 1'b0;
      r_bitcnt     <= '0;
      r_latcnt     <= '0;
      r_ra         <= L_IDLADDR;
      r_step_req   <= 1'b0;
      r_step_swap  <= 1'b0;
      r_step_final <= 1'b0;
      r_step_bit   <= '0;
    end else begin
      r_state    <= w_next;
      r_step_req <= 1'b0;
      case (r_state)
        S_RDK: begin
          r_ra     <= L_KADDR;
          r_latcnt <= '0;
        end
        S_WAITK: r_latcnt <= r_latcnt + 3'd1;
        S_LOAD: begin
          r_kreg     <= ladd_rd;
          r_bitcnt   <= L_LASTBIT;
          r_swap_acc <= 1'b0;
          r_ra       <= L_IDLADDR;
        end
        S_STEP: begin
          r_step_req   <= 1'b1;
          r_step_bit   <= r_bitcnt;
          r_step_swap  <= r_swap_acc ^ w_kbit;
          r_swap_acc   <= w_kbit;
          r_step_final <= 1'b0;
        end
        S_SWAIT: if (step_done && (r_bitcnt != '0)) r_bitcnt <= r_bitcnt - 1'b1;
        S_FINAL: begin
          r_step_req   <= 1'b1;
          r_step_final <= 1'b1;
          r_step_swap  <= r_swap_acc;
          r_step_bit   <= '0;
        end
        S_DONE: begin
          r_step_final <= 1'b0;
          r_step_swap  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ladd_ra    = r_ra;
  assign step_req   = r_step_req;
  assign step_swap  = r_step_swap;
  assign step_final = r_step_final;
  assign step_bit   = r_step_bit;

endmodule
